seq_mulx: RTL
=============

SEQ_MULX -- requirements
Module: seq_mulx

Interface
REQ-001 SHALL have parameter XLEN, 32, operand width (≥8, even).
REQ-002 SHALL have parameter ZERO_SKIP, 1, enables zero-operand fast path when 1.
REQ-003 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  block can accept a request this cycle.
REQ-007 op_i  input  2  mode: 00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
REQ-008 a_i, b_i  input  XLEN each  operands, sampled only on accept.
REQ-009 kill_i  input  1  abort in-flight operation.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer takes result.
REQ-012 result_o  output  XLEN  selected product word.

Function
REQ-013 Accept SHALL occur when valid_i & ready_o & ~kill_i; a_i, b_i, op_i captured.
REQ-014 States IDLE, CALC, FIX, DONE; ready_o = IDLE | (DONE & ready_i), combinational.
REQ-015 IDLE: accept -> CALC, or -> DONE if ZERO_SKIP=1 and a_i or b_i is zero; no accept -> IDLE.
REQ-016 Accept SHALL latch |a|, |b| (magnitude per op signedness: MULH both signed, MULHSU a only, MULHU/MUL none) and neg = sign(a) XOR sign(b) for signed operands.
REQ-017 CALC: radix-2 shift-add on a 2·XLEN+1-bit accumulator, one bit per cycle, exactly XLEN cycles via counter, then -> FIX.
REQ-018 FIX: if neg, accumulator replaced by its 2·XLEN-bit two's complement; -> DONE; one cycle always.
REQ-019 DONE: valid_o=1, result_o = low XLEN bits for MUL, high XLEN bits otherwise; both held stable until ready_i.
REQ-020 Latency: accept in cycle 0 -> valid_o first high in cycle XLEN+2; zero fast path -> cycle 1 with result_o=0.
REQ-021 DONE & ready_i & valid_i SHALL retire the result and accept the new request in the same cycle (back-to-back).
REQ-022 DONE & ready_i & ~valid_i -> IDLE, valid_o low next cycle.
REQ-023 kill_i SHALL force IDLE next cycle from any state, discard the operation, deassert valid_o; kill_i overrides valid_i and ready_i same cycle.
REQ-024 -2^(XLEN-1) operands SHALL produce correct products (magnitude held in XLEN bits unsigned).
REQ-025 result_o SHALL be 0 whenever valid_o=0.

Reset
REQ-026 rst_i SHALL force IDLE, valid_o=0, result_o=0, counter=0, accumulator=0, any cycle including mid-CALC; ready_o=1 first cycle after reset release.
REQ-027 rst_i SHALL take priority over kill_i and valid_i.

Structure
REQ-028 Op encodings (MUL/MULH/MULHSU/MULHU) and state encoding SHALL live in shared package mul_pkg.
REQ-029 Conditional negation (magnitude and FIX) SHALL be one sub-module mul_neg, parametrised by width, instantiated three times.

Verification (XLEN=32)
REQ-030 MULHU a=0xFFFFFFFF b=0xFFFFFFFF accepted cycle 0 -> valid_o cycle 34, result_o=0xFFFFFFFE.
REQ-031 MUL a=0xFFFFFFF9 (-7) b=3 -> result_o=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
REQ-032 MULHSU a=0x80000000 b=0xFFFFFFFF -> result_o=0x80000000; MULH a=b=0x80000000 -> 0x40000000.
REQ-033 MUL a=0 b=0x1234 -> valid_o cycle 1, result_o=0; ready_i held low 5 cycles -> result_o, valid_o stable, then ready_i with valid_i accepts next op same cycle.
REQ-034 kill_i at cycle 10 of MULHU -> valid_o never asserts, ready_o=1 cycle 11; following MUL 6×7 -> 0x0000002A.
REQ-035 rst_i at cycle 15 mid-CALC -> valid_o=0, result_o=0, ready_o=1 next cycle; following op correct.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_pkg : shared op and state encodings for the sequential multiplier |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    function automatic logic op_a_signed(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input mul_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_neg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_neg : conditional two's complement negation of a WIDTH-bit word   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mul_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_neg ? (-i_data) : i_data;

endmodule
`default_nettype wire

// File: rtl/seq_mulx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mulx : radix-2 sequential multiplier, MUL/MULH/MULHSU/MULHU       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_mulx
    import mul_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ZERO_SKIP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int c_CNT_W = $clog2(XLEN);
    localparam int c_ACC_W = 2 * XLEN + 1;

    mul_state_e           r_state;
    mul_state_e           w_next_state;
    mul_op_e              r_op;
    logic                 r_neg;
    logic [XLEN-1:0]      r_mcand;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;

    mul_op_e              w_op;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [XLEN-1:0]      w_a_mag;
    logic [XLEN-1:0]      w_b_mag;
    logic                 w_zero;
    logic                 w_accept;
    logic                 w_last;
    logic [XLEN:0]        w_sum;
    logic [c_ACC_W-1:0]   w_acc_shift;
    logic [2*XLEN-1:0]    w_acc_fix;

    assign w_op     = mul_op_e'(op_i);
    assign w_a_neg  = op_a_signed(w_op) & a_i[XLEN-1];
    assign w_b_neg  = op_b_signed(w_op) & b_i[XLEN-1];
    assign w_zero   = (ZERO_SKIP != 0) && ((a_i == '0) || (b_i == '0));
    assign ready_o  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
    assign w_accept = valid_i & ready_o & ~kill_i;
    assign w_last   = (r_cnt == c_CNT_W'(XLEN - 1));

    mul_neg #(.WIDTH(XLEN)) u_neg_a (
        .i_data (a_i),
        .i_neg  (w_a_neg),
        .o_data (w_a_mag)
    );

    mul_neg #(.WIDTH(XLEN)) u_neg_b (
        .i_data (b_i),
        .i_neg  (w_b_neg),
        .o_data (w_b_mag)
    );

    mul_neg #(.WIDTH(2 * XLEN)) u_neg_fix (
        .i_data (r_acc[2*XLEN-1:0]),
        .i_neg  (r_neg),
        .o_data (w_acc_fix)
    );

    // Upper half never exceeds XLEN bits before the add, so the sum fits XLEN+1.
    assign w_sum       = r_acc[c_ACC_W-1:XLEN] + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_shift = {1'b0, w_sum, r_acc[XLEN-1:1]};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next_state = w_zero ? ST_DONE : ST_CALC;
                end else if ((r_state == ST_DONE) && ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX:  w_next_state = ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
        if (kill_i) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MUL;
            r_neg   <= 1'b0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op    <= w_op;
                r_neg   <= w_a_neg ^ w_b_neg;
                r_mcand <= w_a_mag;
                r_cnt   <= '0;
                r_acc   <= w_zero ? '0 : {{(XLEN + 1){1'b0}}, w_b_mag};
            end else if (r_state == ST_CALC) begin
                r_acc <= w_acc_shift;
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == ST_FIX) begin
                r_acc <= {1'b0, w_acc_fix};
            end
        end
    end

    always_comb begin
        valid_o  = (r_state == ST_DONE);
        result_o = '0;
        if (r_state == ST_DONE) begin
            result_o = (r_op == OP_MUL) ? r_acc[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
        end
    end

endmodule
`default_nettype wire
